decode_stage: RTL

- Parametrised successor to the single-cycle decode block: the ID stage of the pipelined MIPS core.
- Contains:
  - a resettable register file with write-to-read bypass
  - opcode-selected sign/zero immediate extension
  - load-use hazard detection with a one-cycle stall
  - a registered ID/EX pipeline register with valid bit and flush.
- Sits between IF/ID and EX. Writeback drives its write port.

---
 rtl/cpu_defs_pkg.sv | 28 ++
 rtl/reg_file_bypass.sv | 46 ++++
 rtl/decode_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared MIPS decode definitions: opcodes, default widths and small
// opcode classification helpers used by the ID stage.
package cpu_defs;

   localparam int DATA_W_DEF     = 32;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int IMM_W_DEF      = 16;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Instructions that read rt as a source operand (not as a destination).
   function automatic logic op_uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic op_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Register file: two combinational read ports, one write port, register 0
// hard-wired to zero, async clear, and write-to-read bypass so a value being
// written back this cycle is visible to a read in the same cycle.
module reg_file_bypass #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0]     rdata1,
   output logic [DATA_W-1:0]     rdata2
);

   localparam int NREGS = 2**REG_ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic              wr_hit;

   // A write to register 0 is treated as no write at all.
   assign wr_hit = we && (waddr != '0);

   // Storage: cleared asynchronously, written on the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: zero register first, then bypass, then stored value.
   always_comb begin
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
      if (raddr1 == '0)                         rdata1 = '0;
      else if (wr_hit && (waddr == raddr1))     rdata1 = wdata;
      if (raddr2 == '0)                         rdata2 = '0;
      else if (wr_hit && (waddr == raddr2))     rdata2 = wdata;
   end

endmodule

// File: rtl/decode_stage.sv
// ID stage of the pipelined MIPS core: field extraction, register read with
// bypass, immediate extension, load-use hazard detection and the ID/EX
// pipeline register.
//
// Flow control: in_valid qualifies the IF/ID contents. stall is the
// back-pressure signal; when stall=1 the upstream must hold PC and IF/ID so
// the same instruction is presented again next cycle, while ID/EX takes a
// bubble. flush kills whatever would enter ID/EX and overrides stall.
// ex_valid qualifies every ex_* field; fields other than ex_mem_read are
// don't-care when ex_valid=0.
module decode_stage
   import cpu_defs::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int IMM_W      = IMM_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [31:0]           instruction,
   input  logic [DATA_W-1:0]     pc_plus4,
   input  logic                  flush,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0]     wb_write_data,
   output logic                  stall,
   output logic                  ex_valid,
   output logic [5:0]            ex_opcode,
   output logic [5:0]            ex_funct,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [DATA_W-1:0]     ex_read_data1,
   output logic [DATA_W-1:0]     ex_read_data2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic                  ex_mem_read
);

   logic [5:0]            opcode;
   logic [5:0]            funct;
   logic [REG_ADDR_W-1:0] rs, rt, rd;
   logic [IMM_W-1:0]      imm_raw;
   logic [DATA_W-1:0]     imm_ext;
   logic [DATA_W-1:0]     read_data1, read_data2;
   logic                  hazard;

   assign opcode  = instruction[31:26];
   assign funct   = instruction[5:0];
   assign rs      = instruction[21 +: REG_ADDR_W];
   assign rt      = instruction[16 +: REG_ADDR_W];
   assign rd      = instruction[11 +: REG_ADDR_W];
   assign imm_raw = instruction[IMM_W-1:0];

   reg_file_bypass #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_reg_write),
      .waddr  (wb_write_reg),
      .wdata  (wb_write_data),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (read_data1),
      .rdata2 (read_data2)
   );

   // Immediate extension selected by opcode.
   always_comb begin
      imm_ext = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
      if (op_zero_ext(opcode)) imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
   end

   // Load-use hazard: the LW in EX writes a register this instruction reads.
   always_comb begin
      hazard = in_valid && ex_valid && ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == rs) || (op_uses_rt(opcode) && (ex_rt == rt)));
      stall  = hazard && !flush;
   end

   // ID/EX register: flush and stall insert a bubble, otherwise load ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_opcode     <= '0;
         ex_funct      <= '0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_rd         <= '0;
         ex_read_data1 <= '0;
         ex_read_data2 <= '0;
         ex_imm        <= '0;
         ex_pc_plus4   <= '0;
      end else if (flush || stall) begin
         ex_valid      <= 1'b0;
         ex_mem_read   <= 1'b0;
      end else begin
         ex_valid      <= in_valid;
         ex_mem_read   <= in_valid && (opcode == OP_LW);
         ex_opcode     <= opcode;
         ex_funct      <= funct;
         ex_rs         <= rs;
         ex_rt         <= rt;
         ex_rd         <= rd;
         ex_read_data1 <= read_data1;
         ex_read_data2 <= read_data2;
         ex_imm        <= imm_ext;
         ex_pc_plus4   <= pc_plus4;
      end
   end

endmodule
